// File: rtl/stack_bus_pkg.sv
// Shared stack bus definitions: packet control encodings, arbiter state and mode constants.
package stack_bus_pkg;

    localparam logic [1:0] SB_CNTL_SOM_EOM = 2'b00;
    localparam logic [1:0] SB_CNTL_SOM     = 2'b01;
    localparam logic [1:0] SB_CNTL_MOM     = 2'b10;
    localparam logic [1:0] SB_CNTL_EOM     = 2'b11;

    localparam logic SB_ARB_RR    = 1'b0;
    localparam logic SB_ARB_FIXED = 1'b1;

    typedef enum logic [0:0] {
        SB_ARB_IDLE = 1'b0,
        SB_ARB_XFER = 1'b1
    } sb_arb_state_e;

    // True for a word that may legally open a packet.
    function automatic logic sb_is_som(input logic [1:0] cntl);
        return (cntl == SB_CNTL_SOM) || (cntl == SB_CNTL_SOM_EOM);
    endfunction

    // True for a word that closes a packet.
    function automatic logic sb_is_eom(input logic [1:0] cntl);
        return (cntl == SB_CNTL_EOM) || (cntl == SB_CNTL_SOM_EOM);
    endfunction

endpackage

// File: rtl/stack_bus_fifo.sv
// Per-channel word FIFO with registered count and full flag; head is shown combinationally.
module stack_bus_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    // Qualify push/pop and compute the next occupancy.
    always_comb begin
        w_push      = i_push && !r_full;
        w_pop       = i_pop && (r_count != '0);
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    // Pointers, count and full flag; full is registered so ready never depends on a same-cycle pop.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = r_full;

endmodule

// File: rtl/stack_bus_upstream_arbiter.sv
// Concentrates NUM_CH PE upstream channels onto one manager port, whole packets at a time.
module stack_bus_upstream_arbiter
    import stack_bus_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_poweron,
    input  logic [NUM_CH-1:0]            pe__sbu__valid,
    input  logic [2*NUM_CH-1:0]          pe__sbu__cntl,
    input  logic [NUM_CH*DATA_WIDTH-1:0] pe__sbu__data,
    output logic [NUM_CH-1:0]            sbu__pe__ready,
    input  logic                         cfg__sbu__priority_mode,
    output logic                         sbu__mgr__valid,
    output logic [1:0]                   sbu__mgr__cntl,
    output logic [DATA_WIDTH-1:0]        sbu__mgr__data,
    output logic [$clog2(NUM_CH)-1:0]    sbu__mgr__chan,
    input  logic                         mgr__sbu__ready,
    output logic [NUM_CH-1:0]            sbu__sys__proto_err
);

    localparam int unsigned CHW = $clog2(NUM_CH);
    localparam int unsigned SW  = CHW + 1;
    localparam int unsigned FW  = DATA_WIDTH + 2;

    sb_arb_state_e         r_state;
    sb_arb_state_e         w_state_nxt;
    logic [CHW-1:0]        r_chan;
    logic [CHW-1:0]        w_chan_nxt;
    logic [CHW-1:0]        r_rr_ptr;
    logic [CHW-1:0]        w_rr_nxt;
    logic [NUM_CH-1:0]     r_proto_err;
    logic [NUM_CH-1:0]     w_empty;
    logic [NUM_CH-1:0]     w_full;
    logic [NUM_CH-1:0]     w_pop;
    logic [NUM_CH-1:0]     w_cand;
    logic [NUM_CH-1:0]     w_err;
    logic [FW-1:0]         w_head [NUM_CH];
    logic [CHW-1:0]        w_start;
    logic [SW-1:0]         w_sum;
    logic [CHW-1:0]        w_idx;
    logic [CHW-1:0]        w_win;
    logic                  w_found;
    logic [1:0]            w_g_cntl;
    logic [DATA_WIDTH-1:0] w_g_data;
    logic                  w_g_valid;
    logic                  w_g_last;

    // One FIFO per channel plus head classification (packet start vs. protocol error).
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        stack_bus_fifo #(
            .WIDTH (FW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .i_rst   (reset_poweron),
            .i_push  (pe__sbu__valid[gi]),
            .i_data  ({pe__sbu__cntl[2*gi +: 2], pe__sbu__data[gi*DATA_WIDTH +: DATA_WIDTH]}),
            .i_pop   (w_pop[gi]),
            .o_head  (w_head[gi]),
            .o_empty (w_empty[gi]),
            .o_full  (w_full[gi])
        );
        assign sbu__pe__ready[gi] = !w_full[gi];
        assign w_cand[gi]         = !w_empty[gi] &&  sb_is_som(w_head[gi][FW-1 -: 2]);
        assign w_err[gi]          = !w_empty[gi] && !sb_is_som(w_head[gi][FW-1 -: 2]);
    end

    // Head of the currently granted FIFO.
    assign w_g_cntl  = w_head[r_chan][FW-1 -: 2];
    assign w_g_data  = w_head[r_chan][DATA_WIDTH-1:0];
    assign w_g_valid = (r_state == SB_ARB_XFER) && !w_empty[r_chan];
    assign w_g_last  = sb_is_eom(w_g_cntl);

    // Priority search: first packet-start head at or after the start index, wrapping.
    always_comb begin
        w_start = (cfg__sbu__priority_mode == SB_ARB_FIXED) ? '0 : r_rr_ptr;
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int j = 0; j < int'(NUM_CH); j++) begin
            w_sum = {1'b0, w_start} + SW'(j);
            if (w_sum >= SW'(NUM_CH)) w_sum = w_sum - SW'(NUM_CH);
            w_idx = w_sum[CHW-1:0];
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // State register with grant, round-robin pointer and sticky error flags.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_state     <= SB_ARB_IDLE;
            r_chan      <= '0;
            r_rr_ptr    <= '0;
            r_proto_err <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_chan   <= w_chan_nxt;
            r_rr_ptr <= w_rr_nxt;
            if (r_state == SB_ARB_IDLE) r_proto_err <= r_proto_err | w_err;
        end
    end

    // Next-state: grant in IDLE, release on the last word of the packet.
    always_comb begin
        w_state_nxt = r_state;
        w_chan_nxt  = r_chan;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            SB_ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt = SB_ARB_XFER;
                    w_chan_nxt  = w_win;
                end
            end
            SB_ARB_XFER: begin
                if (w_g_valid && mgr__sbu__ready && w_g_last) begin
                    w_state_nxt = SB_ARB_IDLE;
                    w_rr_nxt    = (r_chan == CHW'(NUM_CH - 1)) ? '0 : r_chan + CHW'(1);
                end
            end
            default: w_state_nxt = SB_ARB_IDLE;
        endcase
    end

    // Outputs and pops: drop illegal heads in IDLE, stream the granted FIFO in XFER.
    always_comb begin
        w_pop           = '0;
        sbu__mgr__valid = 1'b0;
        sbu__mgr__cntl  = '0;
        sbu__mgr__data  = '0;
        case (r_state)
            SB_ARB_IDLE: w_pop = w_err;
            SB_ARB_XFER: begin
                sbu__mgr__valid = w_g_valid;
                if (w_g_valid) begin
                    sbu__mgr__cntl = w_g_cntl;
                    sbu__mgr__data = w_g_data;
                end
                if (w_g_valid && mgr__sbu__ready) w_pop[r_chan] = 1'b1;
            end
            default: ;
        endcase
    end

    assign sbu__mgr__chan      = r_chan;
    assign sbu__sys__proto_err = r_proto_err;

endmodule

// File: tb/tb_stack_bus_upstream_arbiter.sv
// Directed bench for the stack bus upstream arbiter.
module tb_stack_bus_upstream_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   pv;
    logic [7:0]   pc;
    logic [127:0] pd;
    logic [3:0]   prdy;
    logic         mode;
    logic         mv;
    logic [1:0]   mc;
    logic [31:0]  md;
    logic [1:0]   mch;
    logic         mrdy;
    logic [3:0]   perr;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] q_data [$];
    logic [1:0]  q_cntl [$];
    logic [1:0]  q_chan [$];
    int          q_cyc  [$];

    always #5 clk = ~clk;

    stack_bus_upstream_arbiter #(
        .NUM_CH     (4),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk                     (clk),
        .reset_poweron           (rst),
        .pe__sbu__valid          (pv),
        .pe__sbu__cntl           (pc),
        .pe__sbu__data           (pd),
        .sbu__pe__ready          (prdy),
        .cfg__sbu__priority_mode (mode),
        .sbu__mgr__valid         (mv),
        .sbu__mgr__cntl          (mc),
        .sbu__mgr__data          (md),
        .sbu__mgr__chan          (mch),
        .mgr__sbu__ready         (mrdy),
        .sbu__sys__proto_err     (perr)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Log every accepted output word with the edge index it was accepted on.
    always @(posedge clk) begin
        if (!rst && mv && mrdy) begin
            q_data.push_back(md);
            q_cntl.push_back(mc);
            q_chan.push_back(mch);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ent(input string tag, input int i, input logic [1:0] ech,
                           input logic [1:0] ect, input logic [31:0] ed);
        if (i < q_data.size()) begin
            chk({tag, "_chan"}, 64'(q_chan[i]), 64'(ech));
            chk({tag, "_cntl"}, 64'(q_cntl[i]), 64'(ect));
            chk({tag, "_data"}, 64'(q_data[i]), 64'(ed));
        end else begin
            chk({tag, "_missing"}, 64'(q_data.size()), 64'(i + 1));
        end
    endtask

    task automatic clr_log();
        q_data.delete();
        q_cntl.delete();
        q_chan.delete();
        q_cyc.delete();
    endtask

    task automatic drive(input int ch, input logic v, input logic [1:0] c, input logic [31:0] d);
        pv[ch]         = v;
        pc[2*ch +: 2]  = c;
        pd[32*ch +: 32] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        pv   = '0;
        pc   = '0;
        pd   = '0;
        mrdy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr_log();
    endtask

    initial begin
        int k;
        int idx;
        int w;
        int base;
        logic [31:0] e_d [3];
        logic [1:0]  e_c [3];

        rst  = 1'b1;
        pv   = '0;
        pc   = '0;
        pd   = '0;
        mode = 1'b0;
        mrdy = 1'b1;

        // Reset state
        #3;
        chk("rst_ready", 64'(prdy), 64'(4'hF));
        chk("rst_valid", 64'(mv),   64'(0));
        chk("rst_cntl",  64'(mc),   64'(0));
        chk("rst_data",  64'(md),   64'(0));
        chk("rst_chan",  64'(mch),  64'(0));
        chk("rst_perr",  64'(perr), 64'(0));

        // Single 3-word packet on ch2
        do_reset();
        mode = 1'b0;
        @(negedge clk);
        k = cyc;
        drive(2, 1'b1, 2'b01, 32'hA1);
        @(negedge clk); drive(2, 1'b1, 2'b10, 32'hA2);
        @(negedge clk); drive(2, 1'b1, 2'b11, 32'hA3);
        @(negedge clk); drive(2, 1'b0, 2'b00, 32'h0);
        repeat (6) @(negedge clk);
        e_d = '{32'hA1, 32'hA2, 32'hA3};
        e_c = '{2'b01, 2'b10, 2'b11};
        chk("t1_count", 64'(q_data.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            chk_ent($sformatf("t1_w%0d", i), i, 2'd2, e_c[i], e_d[i]);
            if (i < q_cyc.size()) chk($sformatf("t1_edge%0d", i), 64'(q_cyc[i]), 64'(k + 2 + i));
        end

        // Round-robin between ch0 and ch1
        do_reset();
        mode = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 2'b00, 32'h10);
        drive(1, 1'b1, 2'b00, 32'h11);
        repeat (12) @(negedge clk);
        drive(0, 1'b0, 2'b00, 32'h0);
        drive(1, 1'b0, 2'b00, 32'h0);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk_ent($sformatf("t2_p%0d", i), i, 2'(i % 2), 2'b00, 32'h10 + 32'(i % 2));
            if (i + 1 < q_cyc.size()) chk($sformatf("t2_gap%0d", i), 64'(q_cyc[i+1] - q_cyc[i]), 64'(2));
        end

        // Fixed priority ch0 over ch3, then switch to round-robin mid-packet
        do_reset();
        mode = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 2'b00, 32'h20);
        drive(3, 1'b1, 2'b00, 32'h23);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_ent($sformatf("t3_fix%0d", i), i, 2'd0, 2'b00, 32'h20);
        w = 0;
        while (!mv && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("t3_wait_valid", 64'(mv), 64'(1));
        base = q_data.size();
        mode = 1'b0;
        repeat (6) @(negedge clk);
        drive(0, 1'b0, 2'b00, 32'h0);
        drive(3, 1'b0, 2'b00, 32'h0);
        repeat (20) @(negedge clk);
        chk_ent("t3_cur", base, 2'd0, 2'b00, 32'h20);
        chk_ent("t3_sw",  base + 1, 2'd3, 2'b00, 32'h23);

        // Backpressure on a 6-word ch1 packet
        do_reset();
        mode = 1'b0;
        idx  = 0;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            if (t >= 4 && t <= 7) begin
                chk($sformatf("t4_hold_v%0d", t),  64'(mv),  64'(1));
                chk($sformatf("t4_hold_d%0d", t),  64'(md),  64'(32'h31));
                chk($sformatf("t4_hold_c%0d", t),  64'(mc),  64'(2'b10));
                chk($sformatf("t4_hold_ch%0d", t), 64'(mch), 64'(1));
            end
            if (t == 5) chk("t4_full_ready", 64'(prdy), 64'(4'b1101));
            mrdy = (t < 3) || (t >= 8);
            if (idx < 6 && prdy[1]) begin
                drive(1, 1'b1, (idx == 0) ? 2'b01 : ((idx == 5) ? 2'b11 : 2'b10), 32'h30 + 32'(idx));
                idx++;
            end else begin
                drive(1, 1'b0, 2'b00, 32'h0);
            end
        end
        mrdy = 1'b1;
        chk("t4_count", 64'(q_data.size()), 64'(6));
        for (int i = 0; i < 6; i++)
            chk_ent($sformatf("t4_w%0d", i), i, 2'd1,
                    (i == 0) ? 2'b01 : ((i == 5) ? 2'b11 : 2'b10), 32'h30 + 32'(i));
        if (q_cyc.size() >= 2) chk("t4_stall_gap", 64'(q_cyc[1] - q_cyc[0]), 64'(6));

        // Protocol error: MOM at the head while IDLE
        do_reset();
        @(negedge clk); drive(1, 1'b1, 2'b10, 32'h55);
        @(negedge clk); drive(1, 1'b0, 2'b00, 32'h0);
        @(negedge clk);
        chk("t5_perr",   64'(perr), 64'(4'b0010));
        chk("t5_valid",  64'(mv),   64'(0));
        chk("t5_ready",  64'(prdy), 64'(4'hF));
        drive(1, 1'b1, 2'b00, 32'h56);
        @(negedge clk); drive(1, 1'b0, 2'b00, 32'h0);
        repeat (5) @(negedge clk);
        chk("t5_count", 64'(q_data.size()), 64'(1));
        chk_ent("t5_next", 0, 2'd1, 2'b00, 32'h56);
        chk("t5_perr_sticky", 64'(perr), 64'(4'b0010));

        // Reset in the middle of a ch3 packet
        do_reset();
        @(negedge clk); drive(3, 1'b1, 2'b01, 32'h60);
        @(negedge clk); drive(3, 1'b1, 2'b10, 32'h61);
        @(negedge clk); drive(3, 1'b1, 2'b10, 32'h62);
        @(negedge clk);
        chk("t6_pre_data", 64'(md),  64'(32'h61));
        chk("t6_pre_chan", 64'(mch), 64'(3));
        #2;
        rst = 1'b1;
        drive(3, 1'b0, 2'b00, 32'h0);
        #1;
        chk("t6_rst_valid", 64'(mv),   64'(0));
        chk("t6_rst_data",  64'(md),   64'(0));
        chk("t6_rst_cntl",  64'(mc),   64'(0));
        chk("t6_rst_chan",  64'(mch),  64'(0));
        chk("t6_rst_ready", 64'(prdy), 64'(4'hF));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clr_log();
        @(negedge clk); drive(3, 1'b1, 2'b01, 32'h70);
        @(negedge clk); drive(3, 1'b1, 2'b11, 32'h71);
        @(negedge clk); drive(3, 1'b0, 2'b00, 32'h0);
        repeat (6) @(negedge clk);
        chk("t6_count", 64'(q_data.size()), 64'(2));
        chk_ent("t6_w0", 0, 2'd3, 2'b01, 32'h70);
        chk_ent("t6_w1", 1, 2'd3, 2'b11, 32'h71);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
